// File: rtl/median_window_ctrl.sv
// Raster-scan 3x3 window sequencer feeding the median unit: two line buffers plus a shift window.
// Optional macro WIN_COORD_EN adds win_row/win_col centre-coordinate outputs.
module median_window_ctrl #(
    parameter int IMG_W = 100,
    parameter int IMG_H = 100,
    parameter int PIX_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PIX_W-1:0]           in_pix,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [9*PIX_W-1:0]         win_data,
    output logic                       busy,
    output logic                       done,
`ifdef WIN_COORD_EN
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
`endif
    output logic [1:0]                 dbg_state
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2, S_DONE = 2'd3} state_t;
    typedef logic [2:0][PIX_W-1:0] column_t;  // [0]=top, [1]=middle, [2]=bottom

    state_t              state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic                win_valid_q, win_valid_d;
    logic [9*PIX_W-1:0]  win_data_q, win_data_d;
    column_t             wc0_q, wc0_d, wc1_q, wc1_d, wc2_q, wc2_d;
    column_t             new_col;
    logic [PIX_W-1:0]    lb0_q [IMG_W];
    logic [PIX_W-1:0]    lb1_q [IMG_W];
    logic                accept, emit;
`ifdef WIN_COORD_EN
    logic [RW-1:0]       win_row_q, win_row_d;
    logic [CW-1:0]       win_col_q, win_col_d;
`endif

    // Both ports are valid/ready: a transfer happens on a rising edge where valid && ready;
    // a producer holds valid and data stable until that edge, and ready may depend on valid.
    assign in_ready  = (state_q == S_RUN) && (!win_valid_q || win_ready);
    assign accept    = in_valid && in_ready;
    assign new_col   = {in_pix, lb0_q[col_q], lb1_q[col_q]};
    assign emit      = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;
`ifdef WIN_COORD_EN
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
`endif

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        wc0_d       = wc0_q;
        wc1_d       = wc1_q;
        wc2_d       = wc2_q;
`ifdef WIN_COORD_EN
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
`endif
        if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RUN: begin
                if (accept && row_q == ROW_LAST && col_q == COL_LAST) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Input is closed here, so the window on the port is the frame's last one.
                if (win_valid_q && win_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            wc0_d = wc1_q;
            wc1_d = wc2_q;
            wc2_d = new_col;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (emit) begin
            win_valid_d = 1'b1;
            for (int r = 0; r < 3; r++) begin
                win_data_d[PIX_W*(3*r+0) +: PIX_W] = wc1_q[r];
                win_data_d[PIX_W*(3*r+1) +: PIX_W] = wc2_q[r];
                win_data_d[PIX_W*(3*r+2) +: PIX_W] = new_col[r];
            end
`ifdef WIN_COORD_EN
            win_row_d = row_q - RW'(1);
            win_col_d = col_q - CW'(1);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            wc0_q       <= '0;
            wc1_q       <= '0;
            wc2_q       <= '0;
`ifdef WIN_COORD_EN
            win_row_q   <= '0;
            win_col_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            wc0_q       <= wc0_d;
            wc1_q       <= wc1_d;
            wc2_q       <= wc2_d;
`ifdef WIN_COORD_EN
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
`endif
        end
    end

    // Line buffers carry no reset: every entry is written before it feeds a window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= in_pix;
        end
    end
endmodule
